dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined core: it serves the processor's dmem port (`address_dmem`, `data`, `wren`, `q_dmem`) with a word-addressed RAM plus a small memory-mapped I/O page. The MMIO page holds an LED register, a free-running cycle counter with a compare timer, and a transmit FIFO. The FIFO is drained by an external consumer over a valid/ready handshake. The core has no dmem stall, so every access completes at fixed latency.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; must be a power of two.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two and ≥ 2.
- `LED_WIDTH`, 16: width of the LED output register.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address_dmem`  in  32  word address from the core.
- `data`  in  32  write data from the core.
- `wren`  in  1  write enable from the core.
- `q_dmem`  out  32  read data to the core, registered.
- `leds`  out  LED_WIDTH  LED register contents.
- `timer_irq`  out  1  sticky timer-match flag.
- `tx_valid`  out  1  FIFO is non-empty.
- `tx_data`  out  32  FIFO head entry.
- `tx_ready`  in  1  consumer accepts the head entry.

## Operation
- **Address decode.**
  - RAM: addresses below `DEPTH`.
  - MMIO: `address_dmem[31:16] == 16'hFFFF`; offset is `address_dmem[3:0]`.
  - Anything else: reads return 0, writes are ignored.
- **MMIO offsets.**
  - 0 LED (RW): low `LED_WIDTH` bits; upper bits read as 0.
  - 1 CYCLE (RO): 32-bit counter; increments every cycle and wraps from `0xFFFFFFFF` to 0.
  - 2 COMPARE (RW): 32-bit timer compare value.
  - 3 TSTAT (RW1C): bit0 = match.
  - 4 TXPUSH (WO): a write enqueues `data`; reads return 0.
  - 5 TXSTAT: [7:0] = count (RO); bit8 = overflow (RW1C); bit9 = full (RO); bit10 = empty (RO).
  - 6–15: reserved; read 0, writes ignored.
- **Timer.** Match sets when CYCLE == COMPARE. The match is sticky until cleared by writing 1 to TSTAT bit0. If a set and a clear happen in the same cycle, set wins. `timer_irq` = match.
- **FIFO push.** A push while full is dropped and sets overflow; stored entries are unchanged.
- **FIFO pop.** Pops when `tx_valid & tx_ready`. `tx_data` is the head and stays stable while `tx_valid & !tx_ready`.
- **Simultaneous push and pop.**
  - Not full: both happen and the count is unchanged.
  - Full: the pop frees a slot and the push is accepted; no overflow.
  - Empty: the push is accepted; no pop occurs, since `tx_valid` was 0.
- **Read-during-write.** To the same RAM address, return old data (read-first). For MMIO registers, return the pre-write value.

## Timing
- **Writes** take effect on the rising edge where `wren` = 1.
- **Read latency** is 1 cycle.
  - `q_dmem` after edge N reflects the address and state sampled at edge N.
  - A CYCLE read returns the counter value before that edge's increment.
- **Status visibility.** FIFO count and status change at the same edge as the push or pop. A TXSTAT read issued one cycle after a push shows the new count.
- **Reset values** (asynchronous, immediate on `reset` low):
  - `q_dmem` = 0, `leds` = 0, CYCLE = 0.
  - COMPARE = `0xFFFFFFFF`; match and overflow = 0.
  - FIFO empty: `tx_valid` = 0, `tx_data` = 0.
- **Reset mid-operation.** Reset aborts in-flight pushes and empties the FIFO. RAM contents are not reset.
- **Reset release.** The first counter increment occurs at the first rising edge after `reset` goes high.

## Structure
- **Package `dmem_pkg`:** `MMIO_BASE_HI` = `16'hFFFF`, offset constants `OFF_LED`, `OFF_CYCLE`, `OFF_COMPARE`, `OFF_TSTAT`, `OFF_TXPUSH`, `OFF_TXSTAT`, and the TXSTAT bit positions.
- **Sub-module `tx_fifo`**, parameterised on depth and width.
  - Circular buffer with read and write pointers plus a count register.
  - Ports: push, push_data, pop, head, count, full, empty.
  - The overflow flag lives in the parent.
- **RAM:** a plain inferred array, synchronous write, registered read.

## Test plan
- **RAM basic and read-first:**
  - Write `0x12345678` to address 5, then read 5 → `q_dmem` = `0x12345678` one cycle later.
  - Write `0xAAAA0000` to 5 while reading 5 → returns `0x12345678`.
  - Read 5 again → returns `0xAAAA0000`.
- **Unmapped access:** write `0xDEADBEEF` to `DEPTH`+3, then read that address → 0. Read address 7 → unchanged.
- **Timer:**
  - After reset, write COMPARE = 20 → `timer_irq` rises at the edge where CYCLE == 20 and stays high.
  - Write TSTAT = 1 → clears.
  - Clear issued on a match cycle → stays set.
- **FIFO fill and overflow** (`tx_ready` = 0):
  - Push 1, 2, 3, 4, 5 → TXSTAT = count 4, full, overflow.
  - Raise `tx_ready` → `tx_data` sequence 1, 2, 3, 4, then `tx_valid` = 0.
  - Write TXSTAT bit8 = 1 → overflow cleared.
- **Push and pop when full:** with the FIFO full and `tx_ready` = 1, push 9 → count stays 4, overflow stays 0, and 9 drains last.
- **Reset mid-stream:** hold `tx_ready` = 0 with 3 entries queued, LED = `0x00FF`, then assert `reset` low asynchronously between edges → `tx_valid`, `leds`, `q_dmem`, and CYCLE drop to 0 immediately; RAM contents are preserved.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: MMIO page location, register offsets
// and status bit positions.
package dmem_pkg;

    localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

    localparam logic [3:0] OFF_LED     = 4'd0;
    localparam logic [3:0] OFF_CYCLE   = 4'd1;
    localparam logic [3:0] OFF_COMPARE = 4'd2;
    localparam logic [3:0] OFF_TSTAT   = 4'd3;
    localparam logic [3:0] OFF_TXPUSH  = 4'd4;
    localparam logic [3:0] OFF_TXSTAT  = 4'd5;

    localparam int TSTAT_MATCH_BIT  = 0;
    localparam int TXSTAT_OVF_BIT   = 8;
    localparam int TXSTAT_FULL_BIT  = 9;
    localparam int TXSTAT_EMPTY_BIT = 10;

    function automatic logic [31:0] pack_txstat(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] v;
        v                   = 32'd0;
        v[7:0]              = count;
        v[TXSTAT_OVF_BIT]   = ovf;
        v[TXSTAT_FULL_BIT]  = full;
        v[TXSTAT_EMPTY_BIT] = empty;
        return v;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Circular-buffer transmit FIFO with read/write pointers and an occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus an MMIO page with LEDs,
// a cycle counter/compare timer and a transmit FIFO. Fixed one-cycle read latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q_dmem,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 timer_irq,
    output logic                 tx_valid,
    output logic [31:0]          tx_data,
    input  logic                 tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]          ram_r [DEPTH];
    logic [31:0]          q_r;
    logic [LED_WIDTH-1:0] led_r;
    logic [31:0]          cycle_r;
    logic [31:0]          compare_r;
    logic                 match_r;
    logic                 ovf_r;

    logic                 is_ram_s;
    logic                 is_mmio_s;
    logic [3:0]           offset_s;
    logic [AW-1:0]        ram_idx_s;
    logic                 mmio_we_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 tstat_clr_s;
    logic                 ovf_clr_s;
    logic                 ovf_set_s;
    logic                 match_set_s;
    logic [31:0]          rd_data_s;
    logic [31:0]          fifo_head_s;
    logic [CW-1:0]        fifo_count_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;

    assign is_ram_s    = ((address_dmem >> AW) == 32'd0);
    assign is_mmio_s   = (address_dmem[31:16] == MMIO_BASE_HI);
    assign offset_s    = address_dmem[3:0];
    assign ram_idx_s   = address_dmem[AW-1:0];
    assign mmio_we_s   = wren & is_mmio_s;
    assign push_s      = mmio_we_s & (offset_s == OFF_TXPUSH);
    assign pop_s       = tx_ready & ~fifo_empty_s;
    assign tstat_clr_s = mmio_we_s & (offset_s == OFF_TSTAT) & data[TSTAT_MATCH_BIT];
    assign ovf_clr_s   = mmio_we_s & (offset_s == OFF_TXSTAT) & data[TXSTAT_OVF_BIT];
    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    assign ovf_set_s   = push_s & fifo_full_s & ~pop_s;
    assign match_set_s = (cycle_r == compare_r);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Read mux over pre-write state, giving read-first behaviour everywhere.
    always_comb begin
        rd_data_s = 32'd0;
        if (is_ram_s) begin
            rd_data_s = ram_r[ram_idx_s];
        end else if (is_mmio_s) begin
            case (offset_s)
                OFF_LED:     rd_data_s = 32'(led_r);
                OFF_CYCLE:   rd_data_s = cycle_r;
                OFF_COMPARE: rd_data_s = compare_r;
                OFF_TSTAT:   rd_data_s = {31'd0, match_r};
                OFF_TXSTAT:  rd_data_s = pack_txstat(8'(fifo_count_s), ovf_r,
                                                     fifo_full_s, fifo_empty_s);
                default:     rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // RAM array: synchronous write, contents survive reset.
    always_ff @(posedge clock) begin
        if (wren && is_ram_s) begin
            ram_r[ram_idx_s] <= data;
        end
    end

    // MMIO registers, timer and registered read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_r       <= 32'd0;
            led_r     <= {LED_WIDTH{1'b0}};
            cycle_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            match_r   <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            q_r     <= rd_data_s;
            cycle_r <= cycle_r + 32'd1;
            // Set has priority over a same-cycle clear for both sticky flags.
            match_r <= match_set_s | (match_r & ~tstat_clr_s);
            ovf_r   <= ovf_set_s | (ovf_r & ~ovf_clr_s);
            if (mmio_we_s && (offset_s == OFF_LED)) begin
                led_r <= data[LED_WIDTH-1:0];
            end
            if (mmio_we_s && (offset_s == OFF_COMPARE)) begin
                compare_r <= data;
            end
        end
    end

    assign q_dmem    = q_r;
    assign leds      = led_r;
    assign timer_irq = match_r;
    assign tx_valid  = ~fifo_empty_s;
    assign tx_data   = fifo_head_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal
// expectations plus randomized traffic against a queue/array reference model.
module tb_dmem_responder;

    localparam int DEPTH      = 4096;
    localparam int FIFO_DEPTH = 4;
    localparam int LED_WIDTH  = 16;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [31:0]          address_dmem;
    logic [31:0]          data;
    logic                 wren;
    logic [31:0]          q_dmem;
    logic [LED_WIDTH-1:0] leds;
    logic                 timer_irq;
    logic                 tx_valid;
    logic [31:0]          tx_data;
    logic                 tx_ready;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LED_WIDTH  (LED_WIDTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .leds         (leds),
        .timer_irq    (timer_irq),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0]          m_cycle;
    logic [31:0]          m_compare;
    logic                 m_match;
    logic                 m_ovf;
    logic [LED_WIDTH-1:0] m_leds;
    logic [31:0]          m_q;
    logic                 m_q_known;
    logic [31:0]          m_fifo [$];
    logic [31:0]          m_ram [int];

    localparam logic [31:0] IDLE_ADDR = 32'h0010_0000;

    function automatic logic [31:0] mmio(input int off);
        return 32'hFFFF_0000 + 32'(off);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cycle   = 32'd0;
        m_compare = 32'hFFFF_FFFF;
        m_match   = 1'b0;
        m_ovf     = 1'b0;
        m_leds    = '0;
        m_q       = 32'd0;
        m_q_known = 1'b1;
        m_fifo.delete();
    endtask

    // Advance the model across one rising edge given the inputs presented to it.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic r);
        logic [31:0] rd;
        logic        known;
        logic        mm;
        int          off;
        int          n;
        logic        was_match_point;
        known = 1'b1;
        rd    = 32'd0;
        mm    = (a[31:16] == 16'hFFFF);
        off   = int'(a[3:0]);
        n     = m_fifo.size();
        if (a < 32'(DEPTH)) begin
            if (m_ram.exists(int'(a))) rd = m_ram[int'(a)];
            else known = 1'b0;
        end else if (mm) begin
            case (off)
                0: rd = 32'(m_leds);
                1: rd = m_cycle;
                2: rd = m_compare;
                3: rd = m_match ? 32'd1 : 32'd0;
                5: rd = 32'(n) + (m_ovf ? 32'h100 : 32'd0)
                        + ((n == FIFO_DEPTH) ? 32'h200 : 32'd0)
                        + ((n == 0) ? 32'h400 : 32'd0);
                default: rd = 32'd0;
            endcase
        end
        was_match_point = (m_cycle == m_compare);
        if (r && n > 0) void'(m_fifo.pop_front());
        if (w && mm && off == 5 && d[8]) m_ovf = 1'b0;
        if (w && mm && off == 4) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(d);
            else m_ovf = 1'b1;
        end
        if (w && mm && off == 3 && d[0]) m_match = 1'b0;
        if (was_match_point) m_match = 1'b1;
        if (w) begin
            if (a < 32'(DEPTH)) m_ram[int'(a)] = d;
            else if (mm && off == 0) m_leds = d[LED_WIDTH-1:0];
            else if (mm && off == 2) m_compare = d;
        end
        m_cycle   = m_cycle + 32'd1;
        m_q       = rd;
        m_q_known = known;
    endtask

    task automatic check_outputs();
        if (m_q_known) chk("q_dmem", q_dmem, m_q);
        chk("leds", 32'(leds), 32'(m_leds));
        chk("timer_irq", 32'(timer_irq), 32'(m_match));
        chk("tx_valid", 32'(tx_valid), (m_fifo.size() > 0) ? 32'd1 : 32'd0);
        if (m_fifo.size() > 0) chk("tx_data", tx_data, m_fifo[0]);
    endtask

    // One clock: drive after the falling edge, step the model, check at next falling edge.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic r);
        address_dmem = a;
        data         = d;
        wren         = w;
        tx_ready     = r;
        model_step(a, d, w, r);
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(IDLE_ADDR, 32'd0, 1'b0, r);
    endtask

    task automatic do_reset();
        wren     = 1'b0;
        tx_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_q_dmem", q_dmem, 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_timer_irq", 32'(timer_irq), 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          kind;
        int          off;
        reset        = 1'b0;
        address_dmem = 32'd0;
        data         = 32'd0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("init_q_dmem", q_dmem, 32'd0);
        chk("init_leds", 32'(leds), 32'd0);
        chk("init_timer_irq", 32'(timer_irq), 32'd0);
        chk("init_tx_valid", 32'(tx_valid), 32'd0);
        chk("init_tx_data", tx_data, 32'd0);
        reset = 1'b1;

        // Timer: COMPARE=20 written while CYCLE=0
        cycle(mmio(2), 32'd20, 1'b1, 1'b0);
        idle(19, 1'b0);
        chk("timer_before_match", 32'(timer_irq), 32'd0);
        idle(1, 1'b0);
        chk("timer_at_match", 32'(timer_irq), 32'd1);
        idle(3, 1'b0);
        chk("timer_sticky", 32'(timer_irq), 32'd1);
        cycle(mmio(3), 32'd1, 1'b1, 1'b0);
        chk("timer_cleared", 32'(timer_irq), 32'd0);

        // Clear on the match cycle loses to set
        do_reset();
        cycle(mmio(2), 32'd5, 1'b1, 1'b0);
        idle(4, 1'b0);
        cycle(mmio(3), 32'd1, 1'b1, 1'b0);
        chk("timer_set_wins", 32'(timer_irq), 32'd1);
        cycle(mmio(3), 32'd1, 1'b1, 1'b0);
        chk("timer_clear_after", 32'(timer_irq), 32'd0);

        // RAM basic and read-first
        cycle(32'd5, 32'h1234_5678, 1'b1, 1'b0);
        cycle(32'd5, 32'd0, 1'b0, 1'b0);
        chk("ram_read", q_dmem, 32'h1234_5678);
        cycle(32'd5, 32'hAAAA_0000, 1'b1, 1'b0);
        chk("ram_read_first", q_dmem, 32'h1234_5678);
        cycle(32'd5, 32'd0, 1'b0, 1'b0);
        chk("ram_read_new", q_dmem, 32'hAAAA_0000);

        // Unmapped access
        cycle(32'd7, 32'h0000_0077, 1'b1, 1'b0);
        cycle(32'(DEPTH + 3), 32'hDEAD_BEEF, 1'b1, 1'b0);
        cycle(32'(DEPTH + 3), 32'd0, 1'b0, 1'b0);
        chk("unmapped_read", q_dmem, 32'd0);
        cycle(32'd7, 32'd0, 1'b0, 1'b0);
        chk("ram7_unchanged", q_dmem, 32'h0000_0077);

        // FIFO fill and overflow
        for (int i = 1; i <= 5; i++) cycle(mmio(4), 32'(i), 1'b1, 1'b0);
        cycle(mmio(5), 32'd0, 1'b0, 1'b0);
        chk("txstat_full_ovf", q_dmem, 32'h0000_0304);
        chk("fifo_head1", tx_data, 32'd1);
        idle(1, 1'b1);
        chk("fifo_head2", tx_data, 32'd2);
        idle(1, 1'b1);
        chk("fifo_head3", tx_data, 32'd3);
        idle(1, 1'b1);
        chk("fifo_head4", tx_data, 32'd4);
        idle(1, 1'b1);
        chk("fifo_drained", 32'(tx_valid), 32'd0);
        cycle(mmio(5), 32'h0000_0100, 1'b1, 1'b0);
        cycle(mmio(5), 32'd0, 1'b0, 1'b0);
        chk("txstat_ovf_cleared", q_dmem, 32'h0000_0400);

        // Push and pop while full
        for (int i = 5; i <= 8; i++) cycle(mmio(4), 32'(i), 1'b1, 1'b0);
        cycle(mmio(4), 32'd9, 1'b1, 1'b1);
        cycle(mmio(5), 32'd0, 1'b0, 1'b0);
        chk("txstat_full_no_ovf", q_dmem, 32'h0000_0204);
        chk("fifo_head6", tx_data, 32'd6);
        idle(3, 1'b1);
        chk("fifo_last9", tx_data, 32'd9);
        idle(1, 1'b1);
        chk("fifo_empty_after9", 32'(tx_valid), 32'd0);

        // Reset mid-stream
        for (int i = 11; i <= 13; i++) cycle(mmio(4), 32'(i), 1'b1, 1'b0);
        cycle(mmio(0), 32'h0000_00FF, 1'b1, 1'b0);
        cycle(mmio(0), 32'd0, 1'b0, 1'b0);
        chk("led_read", q_dmem, 32'h0000_00FF);
        chk("led_out", 32'(leds), 32'h0000_00FF);
        do_reset();
        cycle(mmio(1), 32'd0, 1'b0, 1'b0);
        chk("cycle_after_reset", q_dmem, 32'd0);
        cycle(mmio(1), 32'd0, 1'b0, 1'b0);
        chk("cycle_second", q_dmem, 32'd1);
        cycle(32'd5, 32'd0, 1'b0, 1'b0);
        chk("ram_survives_reset", q_dmem, 32'hAAAA_0000);

        // Randomized traffic
        for (int i = 0; i < 16; i++) cycle(32'(i), $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            kind = int'($urandom_range(0, 9));
            off  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15))
                                               : int'($urandom_range(0, 5));
            d    = $urandom;
            if (kind < 4) begin
                a = 32'($urandom_range(0, 15));
            end else if (kind < 9) begin
                a = {16'hFFFF, 12'($urandom), 4'(off)};
                if (off == 2) d = m_cycle + 32'($urandom_range(1, 10));
            end else begin
                a = 32'(DEPTH) + 32'($urandom_range(0, 60000));
            end
            cycle(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
